// File: rtl/typing_pkg.sv
// Shared types, constants and symbol helpers for the typing game target generator.
// Alphabet selection: define TARGET_DIGITS_EN to add '0'..'9' to the letters.
package typing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [6:0] ASCII_DASH = 7'h2D;
    localparam logic [6:0] ASCII_A    = 7'h41;
    localparam logic [6:0] ASCII_Z    = 7'h5A;
    localparam logic [6:0] ASCII_0    = 7'h30;
    localparam logic [6:0] ASCII_9    = 7'h39;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

`ifdef TARGET_DIGITS_EN
    localparam int unsigned ALPHA_SIZE = 36;
    localparam int unsigned IDX_W      = 6;
`else
    localparam int unsigned ALPHA_SIZE = 26;
    localparam int unsigned IDX_W      = 5;
`endif

    function automatic logic [6:0] idx_to_ascii(input logic [IDX_W-1:0] idx);
`ifdef TARGET_DIGITS_EN
        if (idx < IDX_W'(26)) begin
            return ASCII_A + 7'(idx);
        end
        return ASCII_0 + 7'(idx - IDX_W'(26));
`else
        return ASCII_A + 7'(idx);
`endif
    endfunction

    // Successor in the circular alphabet order used for repeat avoidance.
    function automatic logic [6:0] next_symbol(input logic [6:0] c);
`ifdef TARGET_DIGITS_EN
        if (c == ASCII_Z) begin
            return ASCII_0;
        end
        if (c == ASCII_9) begin
            return ASCII_A;
        end
        return c + 7'd1;
`else
        if (c == ASCII_Z) begin
            return ASCII_A;
        end
        return c + 7'd1;
`endif
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/typing_target_gen_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) mapped onto the target alphabet.
// Alphabet follows TARGET_DIGITS_EN through typing_pkg.
module target_lfsr
    import typing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] target
);

    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic [IDX_W-1:0] idx_raw;
    logic [IDX_W-1:0] idx;

    always_comb begin
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        idx_raw = lfsr_q[IDX_W-1:0];
        // Single subtraction suffices: the raw index never reaches twice the alphabet size.
        idx     = (idx_raw >= IDX_W'(ALPHA_SIZE)) ? idx_raw - IDX_W'(ALPHA_SIZE) : idx_raw;
        target  = idx_to_ascii(idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/typing_target_gen.sv
// Typing game round controller: target selection, keystroke judging, timeout and counters.
// Optional alphabet extension with digits via the TARGET_DIGITS_EN macro.
module typing_target_gen
    import typing_pkg::*;
#(
    parameter int unsigned ROUNDS         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic [6:0] ascii,
    output logic [6:0] selection,
    output logic       round_active,
    output logic       hit,
    output logic       miss,
    output logic       timeout,
    output logic [7:0] score,
    output logic [7:0] errors,
    output logic       done
);

    localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     ROUND_LAST = 8'(ROUNDS - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    round_q, round_d;
    logic [6:0]    prev_q, prev_d;
    logic [6:0]    selection_q, selection_d;
    logic          round_active_q, round_active_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    errors_q, errors_d;
    logic          done_q, done_d;
    logic [6:0]    target;
    logic [6:0]    cand;

    target_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .target (target)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        round_d   = round_q;
        prev_d    = prev_q;
        score_d   = score_q;
        errors_d  = errors_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        timeout_d = 1'b0;
        cand      = (target == prev_q) ? next_symbol(target) : target;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    score_d  = '0;
                    errors_d = '0;
                    round_d  = '0;
                    prev_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
                timer_d = '0;
                prev_d  = cand;
            end
            ST_WAIT: begin
                if (key_valid) begin
                    if (ascii == selection_q) begin
                        hit_d   = 1'b1;
                        score_d = sat_inc(score_q);
                        round_d = round_q + 8'd1;
                        state_d = (round_q == ROUND_LAST) ? ST_DONE : ST_LOAD;
                    end else begin
                        miss_d   = 1'b1;
                        errors_d = sat_inc(errors_q);
                        // Timer parks on its last value so an expiry masked by a miss fires next cycle.
                        if (timer_q != TIMER_LAST) begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    errors_d  = sat_inc(errors_q);
                    round_d   = round_q + 8'd1;
                    state_d   = (round_q == ROUND_LAST) ? ST_DONE : ST_LOAD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_WAIT) begin
            selection_d = (state_q == ST_LOAD) ? cand : selection_q;
        end else begin
            selection_d = ASCII_DASH;
        end
        round_active_d = (state_d == ST_WAIT);
        done_d         = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            round_q        <= '0;
            prev_q         <= '0;
            selection_q    <= ASCII_DASH;
            round_active_q <= 1'b0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            timeout_q      <= 1'b0;
            score_q        <= '0;
            errors_q       <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            round_q        <= round_d;
            prev_q         <= prev_d;
            selection_q    <= selection_d;
            round_active_q <= round_active_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            timeout_q      <= timeout_d;
            score_q        <= score_d;
            errors_q       <= errors_d;
            done_q         <= done_d;
        end
    end

    assign selection    = selection_q;
    assign round_active = round_active_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign timeout      = timeout_q;
    assign score        = score_q;
    assign errors       = errors_q;
    assign done         = done_q;

endmodule

// File: tb/tb_typing_target_gen.sv
// Self-checking bench for typing_target_gen: keystroke table, timeout corners, reset and a long run.
// Event pulses are matched against a queue of expected {event, score, errors} records.
module tb_typing_target_gen;

    localparam int ROUNDS = 3;
    localparam int TO     = 16;

    typedef enum logic [1:0] {EV_HIT, EV_MISS, EV_TO} ev_t;

    typedef struct {
        ev_t        kind;
        logic [7:0] score;
        logic [7:0] errors;
    } exp_t;

    typedef struct {
        bit         use_target;
        logic [6:0] ch;
        ev_t        exp_kind;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       key_valid;
    logic [6:0] ascii;
    logic [6:0] selection;
    logic       round_active;
    logic       hit;
    logic       miss;
    logic       timeout;
    logic [7:0] score;
    logic [7:0] errors;
    logic       done;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   exp_score = 0;
    int   exp_err   = 0;
    int   exp_round = 0;
    exp_t sb[$];
    exp_t mon_e;

    typing_target_gen #(
        .ROUNDS         (ROUNDS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_valid    (key_valid),
        .ascii        (ascii),
        .selection    (selection),
        .round_active (round_active),
        .hit          (hit),
        .miss         (miss),
        .timeout      (timeout),
        .score        (score),
        .errors       (errors),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic in_alpha(input logic [6:0] c);
`ifdef TARGET_DIGITS_EN
        return (c >= 7'h41 && c <= 7'h5A) || (c >= 7'h30 && c <= 7'h39);
`else
        return (c >= 7'h41 && c <= 7'h5A);
`endif
    endfunction

    // Scoreboard consumer: every event pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (hit || miss || timeout)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b timeout=%0b, expected no event (cycle %0d)",
                         hit, miss, timeout, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ev_hit",     {31'd0, hit},     {31'd0, mon_e.kind == EV_HIT});
                check("ev_miss",    {31'd0, miss},    {31'd0, mon_e.kind == EV_MISS});
                check("ev_timeout", {31'd0, timeout}, {31'd0, mon_e.kind == EV_TO});
                check("ev_score",   {24'd0, score},   {24'd0, mon_e.score});
                check("ev_errors",  {24'd0, errors},  {24'd0, mon_e.errors});
            end
        end
    end

    task automatic press(input logic [6:0] ch, input ev_t kind);
        exp_t e;
        if (kind == EV_HIT) begin
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
            exp_round++;
        end else begin
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        end
        e.kind   = kind;
        e.score  = 8'(exp_score);
        e.errors = 8'(exp_err);
        sb.push_back(e);
        key_valid = 1'b1;
        ascii     = ch;
        @(negedge clk);
        key_valid = 1'b0;
        ascii     = 7'h00;
    endtask

    task automatic expect_timeout();
        exp_t e;
        exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        exp_round++;
        e.kind   = EV_TO;
        e.score  = 8'(exp_score);
        e.errors = 8'(exp_err);
        sb.push_back(e);
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_score = 0;
        exp_err   = 0;
        exp_round = 0;
    endtask

    task automatic wait_active(output int t0);
        for (int i = 0; i < 8 && !round_active; i++) @(negedge clk);
        check("round_active_rise", {31'd0, round_active}, 32'd1);
        t0 = cyc;
    endtask

    vec_t tbl[6];

    initial begin
        int         t0;
        logic [6:0] prev;
        logic [6:0] ch;
        int         total;
        int         digit_seen;

        tbl[0] = '{1'b0, 7'h2A, EV_MISS};
        tbl[1] = '{1'b0, 7'h61, EV_MISS};
        tbl[2] = '{1'b1, 7'h00, EV_HIT};
        tbl[3] = '{1'b0, 7'h00, EV_MISS};
        tbl[4] = '{1'b1, 7'h00, EV_HIT};
        tbl[5] = '{1'b1, 7'h00, EV_HIT};

        rst = 1'b1; start = 1'b0; key_valid = 1'b0; ascii = 7'h00;
        repeat (2) @(negedge clk);
        check("rst_selection",    {25'd0, selection},    32'h2D);
        check("rst_score",        {24'd0, score},        32'd0);
        check("rst_errors",       {24'd0, errors},       32'd0);
        check("rst_done",         {31'd0, done},         32'd0);
        check("rst_round_active", {31'd0, round_active}, 32'd0);
        check("rst_lfsr",         {24'd0, dut.u_lfsr.lfsr_q}, 32'hA5);
        rst = 1'b0;
        @(negedge clk);

        // Start latency and keystroke table
        start_game();
        check("load_inactive", {31'd0, round_active}, 32'd0);
        check("load_dash",     {25'd0, selection},    32'h2D);
        @(negedge clk);
        check("start_active",   {31'd0, round_active},       32'd1);
        check("start_in_alpha", {31'd0, in_alpha(selection)}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            prev = selection;
            ch   = tbl[i].use_target ? selection : tbl[i].ch;
            press(ch, tbl[i].exp_kind);
            if (tbl[i].exp_kind == EV_MISS) begin
                check("miss_stays_wait",  {31'd0, round_active}, 32'd1);
                check("miss_keeps_target", {25'd0, selection},   {25'd0, prev});
            end else if (exp_round < ROUNDS) begin
                check("hit_load_dash",     {25'd0, selection},    32'h2D);
                check("hit_load_inactive", {31'd0, round_active}, 32'd0);
                @(negedge clk);
                check("next_active",   {31'd0, round_active},        32'd1);
                check("next_in_alpha", {31'd0, in_alpha(selection)}, 32'd1);
                check("next_differs",  {31'd0, selection != prev},   32'd1);
            end else begin
                check("done_flag",     {31'd0, done},         32'd1);
                check("done_dash",     {25'd0, selection},    32'h2D);
                check("done_inactive", {31'd0, round_active}, 32'd0);
                check("done_score",    {24'd0, score},        32'd3);
                check("done_errors",   {24'd0, errors},       32'd3);
            end
        end

        // Restart from DONE, then miss followed by expiry
        start_game();
        check("restart_score",  {24'd0, score},  32'd0);
        check("restart_errors", {24'd0, errors}, 32'd0);
        check("restart_done",   {31'd0, done},   32'd0);
        @(negedge clk);
        check("restart_active", {31'd0, round_active}, 32'd1);
        t0 = cyc;
        repeat (3) @(negedge clk);
        press(7'h2A, EV_MISS);
        check("miss_errors", {24'd0, errors},       32'd1);
        check("miss_wait",   {31'd0, round_active}, 32'd1);
        expect_timeout();
        for (int i = 0; i < 40 && !timeout; i++) @(negedge clk);
        check("timeout_seen",    {31'd0, timeout}, 32'd1);
        check("timeout_latency", cyc - t0,         TO);
        check("timeout_errors",  {24'd0, errors},  32'd2);

        // Correct key on the expiry cycle wins
        @(negedge clk);
        wait_active(t0);
        repeat (TO - 1) @(negedge clk);
        press(selection, EV_HIT);
        check("key_vs_expiry_no_timeout", {31'd0, timeout},      32'd0);
        check("key_vs_expiry_load",       {31'd0, round_active}, 32'd0);

        // Wrong key on the expiry cycle: miss, then expiry one cycle later
        wait_active(t0);
        repeat (TO - 1) @(negedge clk);
        press(7'h2A, EV_MISS);
        check("miss_on_expiry_open", {31'd0, round_active}, 32'd1);
        expect_timeout();
        @(negedge clk);
        check("late_timeout",         {31'd0, timeout}, 32'd1);
        check("late_timeout_latency", cyc - t0,         TO + 1);
        check("late_timeout_done",    {31'd0, done},    32'd1);

        // Mid-game reset
        start_game();
        wait_active(t0);
        press(selection, EV_HIT);
        wait_active(t0);
        repeat (2) @(negedge clk);
        check("pre_reset_score", {24'd0, score}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_selection", {25'd0, selection},    32'h2D);
        check("mid_rst_active",    {31'd0, round_active}, 32'd0);
        check("mid_rst_score",     {24'd0, score},        32'd0);
        check("mid_rst_errors",    {24'd0, errors},       32'd0);
        check("mid_rst_done",      {31'd0, done},         32'd0);
        check("mid_rst_lfsr",      {24'd0, dut.u_lfsr.lfsr_q}, 32'hA5);
        rst = 1'b0;
        @(negedge clk);

        // Long run: alphabet membership and no back-to-back repeats within a game
        total      = 0;
        digit_seen = 0;
        prev       = 7'h00;
        while (total < 200) begin
            start_game();
            for (int r = 0; r < ROUNDS; r++) begin
                wait_active(t0);
                check("run_in_alpha", {31'd0, in_alpha(selection)}, 32'd1);
                if (r > 0) check("run_no_repeat", {31'd0, selection != prev}, 32'd1);
                if (selection >= 7'h30 && selection <= 7'h39) digit_seen = 1;
                prev = selection;
                press(selection, EV_HIT);
                total++;
            end
            check("run_done", {31'd0, done}, 32'd1);
        end
`ifdef TARGET_DIGITS_EN
        check("run_digit_seen", digit_seen, 32'd1);
`else
        check("run_no_digit", digit_seen, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/typing_target_gen.md
# typing_target_gen

- Generates the target character for each typing round of the Lab4 typing game.
- Drives `selection` into the ASCII comparator and judges each keystroke strobe against the current target.
- Advances on a correct key or on per-round timeout, and keeps score, error and round counters for display.
- Sits between the keyboard decoder output (`ascii`, `key_valid`) and the comparator/seven-segment display path.

## Interface

- ROUNDS, 10: number of targets per game (1..255).
- TIMEOUT_CYCLES, 100_000_000: WAIT cycles allowed per target (1 s at 100 MHz); minimum 2.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  level; begins a game when sampled high in IDLE or DONE.
- key_valid  in  1  one-cycle strobe; `ascii` holds a new keystroke.
- ascii  in  7  keystroke character; sampled only when key_valid=1.
- selection  out  7  current target; 7'h2D ('-') when no round is active.
- round_active  out  1  high while in WAIT.
- hit  out  1  one-cycle pulse on a correct key.
- miss  out  1  one-cycle pulse on a wrong key.
- timeout  out  1  one-cycle pulse when a round expires.
- score  out  8  correct keys this game; saturates at 255.
- errors  out  8  misses plus timeouts; saturates at 255.
- done  out  1  high in DONE.

## Operation

- **LFSR:** 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. Steps every cycle, including IDLE. Seed 8'hA5 on rst.
- **Symbol index:** idx = lfsr[4:0]; if idx ≥ 26, subtract 26.
- **Target:** 7'h41 + idx ('A'..'Z').
- **Repeat avoidance:** if the new target equals the previous target, use the next symbol, wrapping 'Z'→'A'. The previous target is cleared to 7'h00 on start.
- **FSM states:** IDLE, LOAD, WAIT, DONE.
  - IDLE --start--> LOAD; clears score, errors, round index and the previous target.
  - LOAD → WAIT (always). Latches the target into `selection`; timer cleared to 0.
  - WAIT, key_valid and ascii==selection: hit, score+1, round+1. Then LOAD, or DONE if round+1 == ROUNDS.
  - WAIT, key_valid and ascii!=selection: miss, errors+1; stay in WAIT. The timer is not reset.
  - WAIT, no key_valid and timer == TIMEOUT_CYCLES-1: timeout, errors+1, round+1, then LOAD or DONE.
  - WAIT, otherwise: timer+1.
  - DONE --start--> LOAD, with the same clears as from IDLE.
- **Simultaneous key and expiry:** key_valid wins over expiry in the same cycle. A correct key is a hit; a wrong key is a miss and the round stays open one more cycle.
- **start outside IDLE/DONE:** ignored.
- **Counters:** saturate and never wrap.
- **Outside WAIT:** `selection` = 7'h2D and key_valid is ignored.

## Timing

- **Reset values:** state IDLE, lfsr 8'hA5, selection 7'h2D, all flags 0, score 0, errors 0.
- **rst mid-game:** aborts immediately to these reset values.
- **start to target:** start sampled at edge k → LOAD after k. Target on `selection` and round_active=1 after edge k+1.
- **Hit to next target:** key sampled at edge m → hit and score update visible after m. Next target visible after m+2; `selection` shows 7'h2D for the one LOAD cycle.
- **Timeout:** asserts exactly TIMEOUT_CYCLES cycles after round_active rises, if no correct key arrives.
- **Output style:** all outputs are registered; there are no combinational paths from inputs.

## Configuration

- **TARGET_DIGITS_EN defined:**
  - Alphabet is 'A'..'Z' plus '0'..'9' (36 symbols).
  - idx = lfsr[5:0]; if idx ≥ 36, subtract 36.
  - idx 0..25 map to 7'h41+idx; idx 26..35 map to 7'h30+(idx-26).
  - The repeat-avoidance wrap order is 'Z'→'0' and '9'→'A'.
- **Undefined:** letters only, as in Operation.

## Structure

- **Shared package typing_pkg:**
  - FSM state enum.
  - ASCII_DASH = 7'h2D, ASCII_A = 7'h41, ASCII_0 = 7'h30.
  - LFSR_SEED = 8'hA5.
  - Alphabet size constant, selected by TARGET_DIGITS_EN.
- **Sub-module target_lfsr:** free-running LFSR plus index-to-ASCII mapping; output target[6:0].
- **Top:** FSM, timer, round/score/error counters and repeat avoidance.

## Test plan

- **Reset:** rst high 2 cycles → selection=7'h2D, score=0, errors=0, done=0, round_active=0. lfsr=8'hA5 via hierarchical probe.
- **Hit and advance:** start pulse → round_active after 2 edges with selection in 'A'..'Z'. Drive key_valid with ascii=selection → hit for 1 cycle, score=1, then a new selection ≠ the previous one, 2 cycles later.
- **Miss and expiry:** TIMEOUT_CYCLES=16. Wrong key 7'h2A → miss, errors=1, state stays WAIT. With no further keys, timeout fires exactly 16 cycles after round_active rose; errors=2.
- **Game end and restart:** ROUNDS=3, three correct keys → done=1, selection=7'h2D, score=3. start again → score=0, errors=0, a new round begins.
- **Key vs expiry and mid-game reset:** correct key on the expiry cycle → hit, no timeout. rst asserted mid-WAIT → all reset values on the next cycle.
- **TARGET_DIGITS_EN:** 200 rounds → every selection is in 'A'..'Z' or '0'..'9', no consecutive repeats, and at least one digit is observed.
